// File: rtl/matrix_accum_drain_if.sv
// Handshake bundle for matrix_accum_drain: start/config, product-row input stream and result output stream.
// The design owns the slave view; whatever feeds it and drains it uses the master view.
interface matrix_accum_drain_if #(
    parameter int ARR    = 8,
    parameter int PWIDTH = 32,
    parameter int RWIDTH = 32,
    parameter int CNT_W  = 16
);
    logic                    i_start;
    logic [CNT_W-1:0]        cfg_add_nums;
    logic [CNT_W-1:0]        cfg_t_tiles;
    logic [CNT_W-1:0]        cfg_w_tiles;
    logic [CNT_W-1:0]        cfg_t_last;
    logic [CNT_W-1:0]        cfg_w_last;
    logic                    cfg_relu;
    logic                    i_row_valid;
    logic [ARR*PWIDTH-1:0]   i_row_data;
    logic                    i_row_ready;
    logic [RWIDTH-1:0]       o_data;
    logic                    o_valid;
    logic                    o_ready;
    logic                    o_tile_last;
    logic                    o_busy;
    logic                    o_done;

    modport master (
        output i_start, cfg_add_nums, cfg_t_tiles, cfg_w_tiles, cfg_t_last, cfg_w_last, cfg_relu,
        output i_row_valid, i_row_data, o_ready,
        input  i_row_ready, o_data, o_valid, o_tile_last, o_busy, o_done
    );

    modport slave (
        input  i_start, cfg_add_nums, cfg_t_tiles, cfg_w_tiles, cfg_t_last, cfg_w_last, cfg_relu,
        input  i_row_valid, i_row_data, o_ready,
        output i_row_ready, o_data, o_valid, o_tile_last, o_busy, o_done
    );
endinterface

// File: rtl/matrix_accum_drain.sv
// Accumulates ARRxARR partial-product tiles over K-steps, then drains each tile row-major through a
// registered output with valid/ready backpressure, skipping padded rows/columns of the edge tiles.
module matrix_accum_drain #(
    parameter int ARR    = 8,
    parameter int PWIDTH = 32,
    parameter int RWIDTH = 32,
    parameter int CNT_W  = 16,
    parameter int SAT    = 1
) (
    input logic           clk,
    input logic           rstn,
    matrix_accum_drain_if.slave bus
);
    localparam int AW = (ARR > 1) ? $clog2(ARR) : 1;
    localparam logic [AW-1:0]          LAST_POS = AW'(ARR - 1);
    localparam logic [CNT_W-1:0]       ARR_C    = CNT_W'(ARR);
    localparam logic [CNT_W-1:0]       ONE      = CNT_W'(1);
    localparam logic signed [RWIDTH-1:0] ACC_MAX = {1'b0, {(RWIDTH-1){1'b1}}};
    localparam logic signed [RWIDTH-1:0] ACC_MIN = {1'b1, {(RWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          add_q;
    logic [CNT_W-1:0]          t_tiles_q;
    logic [CNT_W-1:0]          w_tiles_q;
    logic [CNT_W-1:0]          t_last_q;
    logic [CNT_W-1:0]          w_last_q;
    logic                      relu_q;
    logic [CNT_W-1:0]          k_cnt;
    logic [CNT_W-1:0]          t_cnt;
    logic [CNT_W-1:0]          w_cnt;
    logic [AW-1:0]             r_cnt;
    logic [AW-1:0]             dr;
    logic [AW-1:0]             dc;
    logic                      walk_done;
    logic signed [RWIDTH-1:0]  acc [ARR][ARR];
    logic signed [RWIDTH-1:0]  sum_p0 [ARR];

    logic                      last_t;
    logic                      last_w;
    logic [CNT_W-1:0]          rows_eff;
    logic [CNT_W-1:0]          cols_eff;
    logic                      padded;
    logic                      at_end;
    logic                      is_tile_last;
    logic                      tile0_last;
    logic                      row_beat;
    logic                      out_free;
    logic                      last_row_beat;

    function automatic logic signed [RWIDTH-1:0] sext(input logic [PWIDTH-1:0] v);
        return RWIDTH'($signed(v));
    endfunction

    function automatic logic signed [RWIDTH-1:0] acc_add(input logic signed [RWIDTH-1:0] a,
                                                         input logic signed [RWIDTH-1:0] b);
        logic signed [RWIDTH:0] s;
        s = (RWIDTH+1)'(a) + (RWIDTH+1)'(b);
        if (SAT != 0 && (s[RWIDTH] != s[RWIDTH-1]))
            return s[RWIDTH] ? ACC_MIN : ACC_MAX;
        return s[RWIDTH-1:0];
    endfunction

    function automatic logic signed [RWIDTH-1:0] out_fn(input logic signed [RWIDTH-1:0] v,
                                                        input logic en);
        return (en && v < 0) ? '0 : v;
    endfunction

    // Stage p0: incoming row merged with the accumulator row it lands on
    always_comb begin
        for (int c = 0; c < ARR; c++) begin
            if (k_cnt == '0)
                sum_p0[c] = sext(bus.i_row_data[(c+1)*PWIDTH-1 -: PWIDTH]);
            else
                sum_p0[c] = acc_add(acc[r_cnt][c], sext(bus.i_row_data[(c+1)*PWIDTH-1 -: PWIDTH]));
        end
    end

    always_comb begin
        last_t        = (t_cnt == t_tiles_q - ONE);
        last_w        = (w_cnt == w_tiles_q - ONE);
        rows_eff      = last_t ? t_last_q : ARR_C;
        cols_eff      = last_w ? w_last_q : ARR_C;
        padded        = (CNT_W'(dr) >= rows_eff) || (CNT_W'(dc) >= cols_eff);
        at_end        = (dr == LAST_POS) && (dc == LAST_POS);
        is_tile_last  = (CNT_W'(dr) == rows_eff - ONE) && (CNT_W'(dc) == cols_eff - ONE);
        tile0_last    = (rows_eff == ONE) && (cols_eff == ONE);
        row_beat      = bus.i_row_valid && bus.i_row_ready;
        out_free      = !bus.o_valid || bus.o_ready;
        last_row_beat = row_beat && (r_cnt == LAST_POS) && (k_cnt == add_q - ONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= S_IDLE;
            add_q           <= ONE;
            t_tiles_q       <= ONE;
            w_tiles_q       <= ONE;
            t_last_q        <= ARR_C;
            w_last_q        <= ARR_C;
            relu_q          <= 1'b0;
            k_cnt           <= '0;
            t_cnt           <= '0;
            w_cnt           <= '0;
            r_cnt           <= '0;
            dr              <= '0;
            dc              <= '0;
            walk_done       <= 1'b0;
            bus.i_row_ready <= 1'b0;
            bus.o_data      <= '0;
            bus.o_valid     <= 1'b0;
            bus.o_tile_last <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
            for (int r = 0; r < ARR; r++)
                for (int c = 0; c < ARR; c++)
                    acc[r][c] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        add_q     <= (bus.cfg_add_nums == '0) ? ONE : bus.cfg_add_nums;
                        t_tiles_q <= (bus.cfg_t_tiles == '0) ? ONE : bus.cfg_t_tiles;
                        w_tiles_q <= (bus.cfg_w_tiles == '0) ? ONE : bus.cfg_w_tiles;
                        t_last_q  <= (bus.cfg_t_last == '0 || bus.cfg_t_last > ARR_C) ? ARR_C : bus.cfg_t_last;
                        w_last_q  <= (bus.cfg_w_last == '0 || bus.cfg_w_last > ARR_C) ? ARR_C : bus.cfg_w_last;
                        relu_q    <= bus.cfg_relu;
                        k_cnt     <= '0;
                        t_cnt     <= '0;
                        w_cnt     <= '0;
                        r_cnt     <= '0;
                        state           <= S_ACCUM;
                        bus.i_row_ready <= 1'b1;
                        bus.o_busy      <= 1'b1;
                    end
                end

                S_ACCUM: begin
                    if (row_beat) begin
                        for (int c = 0; c < ARR; c++)
                            acc[r_cnt][c] <= sum_p0[c];
                        if (r_cnt == LAST_POS) begin
                            r_cnt <= '0;
                            k_cnt <= (k_cnt == add_q - ONE) ? '0 : k_cnt + ONE;
                        end else begin
                            r_cnt <= r_cnt + AW'(1);
                        end
                        // Stage p1: element 0 is never padded and its row is already final
                        // (unless it is the row landing now), so it is presented right away.
                        if (last_row_beat) begin
                            state           <= S_DRAIN;
                            bus.i_row_ready <= 1'b0;
                            bus.o_data      <= out_fn((ARR == 1) ? sum_p0[0] : acc[0][0], relu_q);
                            bus.o_valid     <= 1'b1;
                            bus.o_tile_last <= tile0_last;
                            dr              <= '0;
                            dc              <= AW'((ARR > 1) ? 1 : 0);
                            walk_done       <= (ARR == 1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (out_free) begin
                        if (walk_done || (padded && at_end)) begin
                            bus.o_valid     <= 1'b0;
                            bus.o_tile_last <= 1'b0;
                            walk_done       <= 1'b0;
                            if (last_t && last_w) begin
                                state      <= S_DONE;
                                bus.o_done <= 1'b1;
                            end else begin
                                state           <= S_ACCUM;
                                bus.i_row_ready <= 1'b1;
                                if (last_t) begin
                                    t_cnt <= '0;
                                    w_cnt <= w_cnt + ONE;
                                end else begin
                                    t_cnt <= t_cnt + ONE;
                                end
                            end
                        end else begin
                            if (padded) begin
                                bus.o_valid     <= 1'b0;
                                bus.o_tile_last <= 1'b0;
                            end else begin
                                bus.o_data      <= out_fn(acc[dr][dc], relu_q);
                                bus.o_valid     <= 1'b1;
                                bus.o_tile_last <= is_tile_last;
                            end
                            if (at_end) begin
                                walk_done <= 1'b1;
                            end else if (dc == LAST_POS) begin
                                dc <= '0;
                                dr <= dr + AW'(1);
                            end else begin
                                dc <= dc + AW'(1);
                            end
                        end
                    end
                end

                S_DONE: begin
                    state      <= S_IDLE;
                    bus.o_done <= 1'b0;
                    bus.o_busy <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_accum_drain.sv
// Directed-plus-random bench for matrix_accum_drain (ARR=4, 16-bit saturating): a per-tile arithmetic
// model with explicit padding rules predicts every emitted element, its order and the tile-last marker.
module tb_matrix_accum_drain;
    localparam int ARR = 4;
    localparam int PW  = 16;
    localparam int RW  = 16;
    localparam int CW  = 16;
    localparam longint LIM = longint'(1) << (RW - 1);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    matrix_accum_drain_if #(.ARR(ARR), .PWIDTH(PW), .RWIDTH(RW), .CNT_W(CW)) bus ();

    matrix_accum_drain #(.ARR(ARR), .PWIDTH(PW), .RWIDTH(RW), .CNT_W(CW), .SAT(1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always @(negedge clk) if (bus.o_done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint clip(input longint v);
        if (v > LIM - 1) return LIM - 1;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    function automatic longint sx(input logic [RW-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic feed_row(input logic [ARR*PW-1:0] vec);
        int n = 0;
        bus.i_row_data  = vec;
        bus.i_row_valid = 1'b1;
        while (!bus.i_row_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("row_ready_wait", bus.i_row_ready, 1);
        @(negedge clk);
        bus.i_row_valid = 1'b0;
        bus.i_start     = 1'b0;
    endtask

    task automatic run_conv(input int add_nums, input int t_tiles, input int w_tiles,
                            input int t_last, input int w_last, input bit relu,
                            input int dmode, input longint dval, input int rmode);
        int add_eff = (add_nums == 0) ? 1 : add_nums;
        int tl = (t_last == 0) ? ARR : t_last;
        int wl = (w_last == 0) ? ARR : w_last;
        int done0 = done_cnt;
        longint acc_m [ARR][ARR];
        longint eq [$];
        logic [ARR*PW-1:0] vec;
        longint v, pdata;
        bit rdy, stalled, plast, last_tile;
        int rows_v, cols_v, last_lin, inner, trailing, got, cyc, idle, hold, n;

        bus.cfg_add_nums = CW'(add_nums);
        bus.cfg_t_tiles  = CW'(t_tiles);
        bus.cfg_w_tiles  = CW'(w_tiles);
        bus.cfg_t_last   = CW'(t_last);
        bus.cfg_w_last   = CW'(w_last);
        bus.cfg_relu     = relu;
        bus.i_start      = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("busy_after_start", bus.o_busy, 1);
        check("ready_after_start", bus.i_row_ready, 1);
        bus.cfg_add_nums = CW'($urandom_range(7));
        bus.cfg_t_tiles  = CW'($urandom_range(5));
        bus.cfg_w_tiles  = CW'($urandom_range(5));
        bus.cfg_t_last   = CW'($urandom_range(3));
        bus.cfg_w_last   = CW'($urandom_range(3));
        bus.cfg_relu     = ~relu;

        for (int w = 0; w < w_tiles; w++) begin
            for (int t = 0; t < t_tiles; t++) begin
                rows_v = (t == t_tiles - 1) ? tl : ARR;
                cols_v = (w == w_tiles - 1) ? wl : ARR;
                for (int k = 0; k < add_eff; k++) begin
                    for (int r = 0; r < ARR; r++) begin
                        for (int c = 0; c < ARR; c++) begin
                            if (dmode == 0) v = longint'($urandom_range(40000)) - 20000;
                            else if (dmode == 1) v = r * 10 + c;
                            else v = dval;
                            vec[c*PW +: PW] = PW'(v);
                            acc_m[r][c] = (k == 0) ? v : clip(acc_m[r][c] + v);
                        end
                        if ($urandom_range(3) == 0) @(negedge clk);
                        if (w == 0 && t == 0 && k == 0 && r == 0) bus.i_start = 1'b1;
                        feed_row(vec);
                    end
                end
                check("first_valid", bus.o_valid, 1);
                check("ready_low_after_tile", bus.i_row_ready, 0);

                eq.delete();
                last_lin = (rows_v - 1) * ARR + cols_v - 1;
                inner = 0;
                for (int e = 0; e < ARR * ARR; e++) begin
                    if (e / ARR < rows_v && e % ARR < cols_v)
                        eq.push_back((relu && acc_m[e / ARR][e % ARR] < 0) ? 0 : acc_m[e / ARR][e % ARR]);
                    else if (e < last_lin)
                        inner++;
                end
                trailing = ARR * ARR - 1 - last_lin;

                got = 0; cyc = 0; idle = 0; hold = 0; stalled = 0; pdata = 0; plast = 0;
                while (got < eq.size() && cyc < 500) begin
                    if (rmode == 0) rdy = 1'b1;
                    else if (rmode == 1) rdy = (cyc % 2 == 0);
                    else if (hold > 0) begin rdy = 1'b0; hold--; end
                    else if ($urandom_range(7) == 0) begin rdy = 1'b0; hold = 4; end
                    else rdy = ($urandom_range(1) == 1);
                    bus.o_ready = rdy;
                    check("ready_low_in_drain", bus.i_row_ready, 0);
                    if (stalled) begin
                        check("hold_valid", bus.o_valid, 1);
                        check("hold_data", sx(bus.o_data), pdata);
                        check("hold_last", bus.o_tile_last, plast);
                    end
                    stalled = 1'b0;
                    if (bus.o_valid) begin
                        if (rdy) begin
                            check("data", sx(bus.o_data), eq[got]);
                            check("tile_last", bus.o_tile_last, (got == eq.size() - 1));
                            got++;
                        end else begin
                            stalled = 1'b1;
                            pdata   = sx(bus.o_data);
                            plast   = bus.o_tile_last;
                        end
                    end else if (got > 0) begin
                        idle++;
                    end
                    @(negedge clk);
                    cyc++;
                end
                bus.o_ready = 1'b1;
                check("drain_count", got, eq.size());
                if (rmode == 0) check("inner_pad_cycles", idle, inner);

                last_tile = (t == t_tiles - 1) && (w == w_tiles - 1);
                n = 0;
                while (!(last_tile ? bus.o_done : bus.i_row_ready) && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("tile_end_latency", (trailing == 0) ? n : (n <= trailing), (trailing == 0) ? 0 : 1);
            end
        end
        @(negedge clk);
        check("done_cleared", bus.o_done, 0);
        check("idle_after_done", bus.o_busy, 0);
        check("done_count", done_cnt - done0, 1);
    endtask

    initial begin
        int d0;
        logic [ARR*PW-1:0] rv;
        bus.i_start      = 1'b0;
        bus.cfg_add_nums = '0;
        bus.cfg_t_tiles  = '0;
        bus.cfg_w_tiles  = '0;
        bus.cfg_t_last   = '0;
        bus.cfg_w_last   = '0;
        bus.cfg_relu     = 1'b0;
        bus.i_row_valid  = 1'b0;
        bus.i_row_data   = '0;
        bus.o_ready      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.o_valid, 0);
        check("rst_tile_last", bus.o_tile_last, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_row_ready", bus.i_row_ready, 0);
        check("rst_data", bus.o_data, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_row_ready", bus.i_row_ready, 0);

        run_conv(1, 1, 1, 0, 0, 1'b0, 1, 0, 0);
        run_conv(3, 1, 1, 0, 0, 1'b0, 1, 0, 0);
        run_conv(1, 2, 1, 3, 0, 1'b0, 0, 0, 0);
        run_conv(1, 1, 2, 0, 2, 1'b0, 0, 0, 0);
        run_conv(2, 1, 1, 0, 0, 1'b0, 0, 0, 1);
        run_conv(0, 2, 2, 2, 3, 1'b1, 0, 0, 2);
        run_conv(2, 1, 1, 0, 0, 1'b0, 2, 28672, 0);
        run_conv(1, 1, 1, 0, 0, 1'b1, 2, -5, 0);

        // abort in the middle of a stalled drain
        bus.cfg_add_nums = CW'(1);
        bus.cfg_t_tiles  = CW'(1);
        bus.cfg_w_tiles  = CW'(1);
        bus.cfg_t_last   = '0;
        bus.cfg_w_last   = '0;
        bus.cfg_relu     = 1'b0;
        bus.i_start      = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int r = 0; r < ARR; r++) begin
            for (int c = 0; c < ARR; c++) rv[c*PW +: PW] = PW'(100 + r * 10 + c);
            feed_row(rv);
        end
        bus.o_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("stall_before_reset", bus.o_valid, 1);
        d0 = done_cnt;
        #2 rstn = 1'b0;
        #1;
        check("abort_valid", bus.o_valid, 0);
        check("abort_busy", bus.o_busy, 0);
        check("abort_data", bus.o_data, 0);
        check("abort_row_ready", bus.i_row_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        bus.o_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", bus.o_busy, 0);

        run_conv(3, 2, 2, 1, 1, 1'b0, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
